// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and widths for the structural down counter
package counter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/D_Flip_Flop.sv
// rtl/D_Flip_Flop.sv - single-bit storage cell with synchronous active-high clear
module D_Flip_Flop (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/subtract_by_one_subtractor.sv
// rtl/subtract_by_one_subtractor.sv - ripple-borrow decrement; Bout flags an input of zero
module subtract_by_one_subtractor
    import counter_pkg::*;
(
    input  logic [CNT_W-1:0] A,
    output logic [CNT_W-1:0] D,
    output logic             Bout
);

    // b[0] is the constant borrow-in that turns the chain into A - 1
    logic [CNT_W:0] b;

    assign b[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < CNT_W; i++) begin : g_stage
            assign D[i]   = A[i] ^ b[i];
            assign b[i+1] = ~A[i] & b[i];
        end
    endgenerate

    assign Bout = b[CNT_W];

endmodule

// File: rtl/counter_4_bit_down_structural.sv
// rtl/counter_4_bit_down_structural.sv - prescaled 4-bit down counter, wrap or one-shot, DFF-based storage
module counter_4_bit_down_structural
    import counter_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             one_shot,
    output logic [CNT_W-1:0] out,
    output logic             zero,
    output logic             borrow,
    output logic             busy
);

    localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);

    state_t           state;
    logic             mode;
    logic [PW-1:0]    pre;
    logic             tick;
    logic [CNT_W-1:0] dec;
    logic             bout;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (state == RUN) && en && (pre == PRE_MAX);

    subtract_by_one_subtractor u_sub (
        .A    (out),
        .D    (dec),
        .Bout (bout)
    );

    // A decrement of zero naturally yields 15, so only one-shot mode needs to hold at zero
    always_comb begin
        cnt_d = out;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && !(bout && mode)) begin
            cnt_d = dec;
        end
    end

    genvar i;
    generate
        for (i = 0; i < CNT_W; i++) begin : g_cnt
            D_Flip_Flop u_dff (
                .clk (clk),
                .rst (rst),
                .d   (cnt_d[i]),
                .q   (out[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (load) begin
            pre <= '0;
        end else if ((state == RUN) && en) begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode   <= 1'b0;
            borrow <= 1'b0;
        end else begin
            borrow <= 1'b0;
            if (load) begin
                state <= RUN;
                mode  <= one_shot;
            end else if (tick && bout) begin
                borrow <= 1'b1;
                if (mode) begin
                    state <= DONE;
                end
            end
        end
    end

    assign zero = (out == '0);
    assign busy = (state == RUN);

endmodule

// File: tb/tb_counter_4_bit_down_structural.sv
// tb/tb_counter_4_bit_down_structural.sv - directed bench for DIV=4 and DIV=1 instances
module tb_counter_4_bit_down_structural;

    logic       clk;
    int         checks;
    int         failures;

    logic       a_rst, a_en, a_load, a_one_shot;
    logic [3:0] a_load_val;
    logic [3:0] a_out;
    logic       a_zero, a_borrow, a_busy;

    logic       b_rst, b_en, b_load, b_one_shot;
    logic [3:0] b_load_val;
    logic [3:0] b_out;
    logic       b_zero, b_borrow, b_busy;

    counter_4_bit_down_structural #(.DIV(4)) dut4 (
        .clk      (clk),
        .rst      (a_rst),
        .en       (a_en),
        .load     (a_load),
        .load_val (a_load_val),
        .one_shot (a_one_shot),
        .out      (a_out),
        .zero     (a_zero),
        .borrow   (a_borrow),
        .busy     (a_busy)
    );

    counter_4_bit_down_structural #(.DIV(1)) dut1 (
        .clk      (clk),
        .rst      (b_rst),
        .en       (b_en),
        .load     (b_load),
        .load_val (b_load_val),
        .one_shot (b_one_shot),
        .out      (b_out),
        .zero     (b_zero),
        .borrow   (b_borrow),
        .busy     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_en = 1'b1; a_load = 1'b1; a_load_val = 4'd5; a_one_shot = 1'b1;
        b_rst = 1'b1; b_en = 1'b1; b_load = 1'b1; b_load_val = 4'd5; b_one_shot = 1'b1;
        step();
        checks++;
        if (a_out !== 4'd0 || a_zero !== 1'b1 || a_busy !== 1'b0 || a_borrow !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: out=%0d zero=%b busy=%b borrow=%b required out=0 zero=1 busy=0 borrow=0",
                     a_out, a_zero, a_busy, a_borrow);
        end
        checks++;
        if (b_out !== 4'd0 || b_zero !== 1'b1 || b_busy !== 1'b0 || b_borrow !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: out=%0d zero=%b busy=%b borrow=%b required out=0 zero=1 busy=0 borrow=0",
                     b_out, b_zero, b_busy, b_borrow);
        end
        a_rst = 1'b0; a_load = 1'b0; b_rst = 1'b0; b_load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (a_out !== 4'd0 || a_borrow !== 1'b0 || a_busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold cyc%0d: out=%0d borrow=%b busy=%b required 0 0 0", k, a_out, a_borrow, a_busy);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] seq [4];
        seq[0] = 4'd2; seq[1] = 4'd1; seq[2] = 4'd0; seq[3] = 4'd15;
        a_load = 1'b1; a_load_val = 4'd3; a_one_shot = 1'b0; a_en = 1'b1;
        step();
        a_load = 1'b0;
        checks++;
        if (a_out !== 4'd3 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL wrap_load: out=%0d busy=%b required 3 1", a_out, a_busy);
        end
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 3; k++) begin
                step();
                checks++;
                if (a_out === seq[s] || a_borrow !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_early s%0d k%0d: out=%0d borrow=%b required no step yet, borrow 0", s, k, a_out, a_borrow);
                end
            end
            step();
            checks++;
            if (a_out !== seq[s] || a_borrow !== (seq[s] == 4'd15)) begin
                failures++;
                $display("FAIL wrap_step s%0d: out=%0d borrow=%b required %0d %b", s, a_out, a_borrow, seq[s], seq[s] == 4'd15);
            end
        end
        step();
        checks++;
        if (a_borrow !== 1'b0 || a_busy !== 1'b1 || a_out !== 4'd15) begin
            failures++;
            $display("FAIL wrap_after: borrow=%b busy=%b out=%0d required 0 1 15", a_borrow, a_busy, a_out);
        end
    endtask

    task automatic test_one_shot();
        logic ok;
        a_load = 1'b1; a_load_val = 4'd2; a_one_shot = 1'b1;
        step();
        a_load = 1'b0;
        checks++;
        if (a_out !== 4'd2 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL os_load: out=%0d busy=%b required 2 1", a_out, a_busy);
        end
        for (int s = 1; s >= 0; s--) begin
            repeat (4) step();
            checks++;
            if (a_out !== 4'(s) || a_borrow !== 1'b0) begin
                failures++;
                $display("FAIL os_step: out=%0d borrow=%b required %0d 0", a_out, a_borrow, s);
            end
        end
        repeat (4) step();
        checks++;
        if (a_out !== 4'd0 || a_borrow !== 1'b1 || a_busy !== 1'b0 || a_zero !== 1'b1) begin
            failures++;
            $display("FAIL os_done: out=%0d borrow=%b busy=%b zero=%b required 0 1 0 1", a_out, a_borrow, a_busy, a_zero);
        end
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (a_out !== 4'd0 || a_borrow !== 1'b0 || a_busy !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL os_hold: out=%0d borrow=%b busy=%b required 0 0 0 for 20 cycles", a_out, a_borrow, a_busy);
        end
    endtask

    task automatic test_enable_gating();
        a_load = 1'b1; a_load_val = 4'd5; a_one_shot = 1'b0; a_en = 1'b1;
        step();
        a_load = 1'b0;
        checks++;
        if (a_out !== 4'd5 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL en_load_from_done: out=%0d busy=%b required 5 1", a_out, a_busy);
        end
        step();
        a_en = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 7) a_en = 1'b1;
            step();
            checks++;
            if (a_out !== 4'd5) begin
                failures++;
                $display("FAIL en_hold k%0d: out=%0d required 5", k, a_out);
            end
        end
        step();
        checks++;
        if (a_out !== 4'd4 || a_borrow !== 1'b0) begin
            failures++;
            $display("FAIL en_delayed_step: out=%0d borrow=%b required 4 0", a_out, a_borrow);
        end
    endtask

    task automatic test_load_collision();
        a_load = 1'b1; a_load_val = 4'd0; a_one_shot = 1'b0; a_en = 1'b1;
        step();
        a_load = 1'b0;
        repeat (3) step();
        a_load = 1'b1; a_load_val = 4'd9;
        step();
        a_load = 1'b0;
        checks++;
        if (a_out !== 4'd9 || a_borrow !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL collide: out=%0d borrow=%b busy=%b required 9 0 1", a_out, a_borrow, a_busy);
        end
        repeat (3) step();
        checks++;
        if (a_out !== 4'd9 || a_borrow !== 1'b0) begin
            failures++;
            $display("FAIL collide_prescale: out=%0d borrow=%b required 9 0", a_out, a_borrow);
        end
        step();
        checks++;
        if (a_out !== 4'd8) begin
            failures++;
            $display("FAIL collide_step: out=%0d required 8", a_out);
        end
    endtask

    task automatic test_back_to_back();
        a_load = 1'b1; a_load_val = 4'd6;
        step();
        checks++;
        if (a_out !== 4'd6) begin
            failures++;
            $display("FAIL b2b_first: out=%0d required 6", a_out);
        end
        a_load_val = 4'd4;
        step();
        a_load = 1'b0;
        checks++;
        if (a_out !== 4'd4) begin
            failures++;
            $display("FAIL b2b_second: out=%0d required 4", a_out);
        end
        repeat (3) step();
        checks++;
        if (a_out !== 4'd4) begin
            failures++;
            $display("FAIL b2b_hold: out=%0d required 4", a_out);
        end
        step();
        checks++;
        if (a_out !== 4'd3) begin
            failures++;
            $display("FAIL b2b_step: out=%0d required 3", a_out);
        end
    endtask

    task automatic test_div1_reset_mid();
        logic ok;
        b_load = 1'b1; b_load_val = 4'd7; b_one_shot = 1'b0; b_en = 1'b1;
        step();
        b_load = 1'b0;
        for (int k = 6; k >= 4; k--) begin
            step();
            checks++;
            if (b_out !== 4'(k) || b_busy !== 1'b1) begin
                failures++;
                $display("FAIL d1_tick: out=%0d busy=%b required %0d 1", b_out, b_busy, k);
            end
        end
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        checks++;
        if (b_out !== 4'd0 || b_busy !== 1'b0 || b_borrow !== 1'b0 || b_zero !== 1'b1) begin
            failures++;
            $display("FAIL d1_rst: out=%0d busy=%b borrow=%b zero=%b required 0 0 0 1", b_out, b_busy, b_borrow, b_zero);
        end
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (b_out !== 4'd0 || b_borrow !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL d1_rst_hold: out=%0d borrow=%b required 0 0", b_out, b_borrow);
        end
    endtask

    task automatic test_div1_zero_load();
        b_load = 1'b1; b_load_val = 4'd0; b_one_shot = 1'b1;
        step();
        b_load = 1'b0;
        checks++;
        if (b_out !== 4'd0 || b_busy !== 1'b1 || b_borrow !== 1'b0) begin
            failures++;
            $display("FAIL d1_os_load: out=%0d busy=%b borrow=%b required 0 1 0", b_out, b_busy, b_borrow);
        end
        step();
        checks++;
        if (b_out !== 4'd0 || b_busy !== 1'b0 || b_borrow !== 1'b1) begin
            failures++;
            $display("FAIL d1_os_done: out=%0d busy=%b borrow=%b required 0 0 1", b_out, b_busy, b_borrow);
        end
        step();
        checks++;
        if (b_out !== 4'd0 || b_borrow !== 1'b0) begin
            failures++;
            $display("FAIL d1_os_after: out=%0d borrow=%b required 0 0", b_out, b_borrow);
        end
        b_load = 1'b1; b_one_shot = 1'b0;
        step();
        b_load = 1'b0;
        step();
        checks++;
        if (b_out !== 4'd15 || b_borrow !== 1'b1 || b_busy !== 1'b1) begin
            failures++;
            $display("FAIL d1_wrap: out=%0d borrow=%b busy=%b required 15 1 1", b_out, b_borrow, b_busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_wrap();
        test_one_shot();
        test_enable_gating();
        test_load_collision();
        test_back_to_back();
        test_div1_reset_mid();
        test_div1_zero_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_4_bit_down_structural.md
COUNTER_4_BIT_DOWN_STRUCTURAL -- requirements
Module: counter_4_bit_down_structural

Interface
REQ-001 Parameter: DIV, 4, prescale ratio in clk cycles per count step; legal range 1..256.
REQ-002 Port: clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: en  in  1  count enable; low freezes the prescaler and the counter.
REQ-005 Port: load  in  1  one-cycle load strobe.
REQ-006 Port: load_val  in  4  value captured on load.
REQ-007 Port: one_shot  in  1  mode select, sampled on load; 1 = stop at zero, 0 = wrap.
REQ-008 Port: out  out  4  current count, registered.
REQ-009 Port: zero  out  1  high whenever out == 0; combinational from out.
REQ-010 Port: borrow  out  1  one-cycle pulse on the step that leaves 0.
REQ-011 Port: busy  out  1  high in state RUN.

Function
REQ-012 Three states SHALL exist: IDLE, RUN, DONE.
REQ-013 Transitions SHALL be: IDLE -load-> RUN; RUN -load-> RUN (reload); RUN -(tick at out==0, one-shot mode)-> DONE; DONE -load-> RUN; no other exits.
REQ-014 On load: out SHALL take load_val on the next edge, the mode flag SHALL latch one_shot, and the prescaler SHALL clear to 0, in any state and regardless of en.
REQ-015 Prescaler SHALL count 0..DIV-1 only while state==RUN and en==1, and SHALL hold otherwise.
REQ-016 tick SHALL be asserted internally when prescaler==DIV-1 and en==1 and state==RUN, after which the prescaler SHALL wrap to 0.
REQ-017 With DIV=1, tick SHALL occur every enabled RUN cycle.
REQ-018 On tick with out!=0, out SHALL become out-1, with borrow low.
REQ-019 On tick with out==0 in wrap mode, out SHALL become 15, borrow SHALL pulse for one cycle, and state SHALL stay RUN.
REQ-020 On tick with out==0 in one-shot mode, out SHALL hold 0, borrow SHALL pulse for one cycle, and state SHALL go to DONE.
REQ-021 load coincident with tick: load SHALL win, with no decrement and no borrow.
REQ-022 In IDLE and DONE, out SHALL hold.
REQ-023 Loading 0 SHALL be legal; the first tick then follows REQ-019 or REQ-020.
REQ-024 Latency: the first decrement SHALL occur DIV enabled cycles after the load edge.

Reset
REQ-025 When rst=1 at an edge: state=IDLE, out=0, prescaler=0, mode flag=0, borrow=0; hence zero=1 and busy=0.
REQ-026 rst SHALL override load and en.
REQ-027 rst mid-count SHALL abandon the count with no borrow pulse.

Structure
REQ-028 Package counter_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the count width constant CNT_W=4.
REQ-029 Count storage SHALL be four D_Flip_Flop instances clocked by clk, with next-state muxing done in logic; no derived clocks.
REQ-030 Decrement SHALL be a sub-module subtract_by_one_subtractor (A[3:0] -> D[3:0], Bout), a ripple-borrow counterpart to the increment adder.
REQ-031 Bout of subtract_by_one_subtractor SHALL source the borrow decision.

Verification
REQ-032 Wrap countdown: DIV=4, load 3, one_shot=0, en=1 -> out 3,2,1,0,15 at 4-cycle spacing; borrow high for exactly the cycle out becomes 15.
REQ-033 One-shot: DIV=4, load 2, one_shot=1 -> out 2,1,0; borrow pulse on the next tick; busy drops; out holds 0 for 20 further cycles.
REQ-034 Enable gating: DIV=4, load 5, drop en for 7 cycles mid-prescale -> decrement delayed by exactly 7 cycles; out stays 5 while en is low.
REQ-035 Load collision: assert load=1 with load_val=9 on the same cycle as a tick at out=0 -> out=9, no borrow, prescaler restarts at 0.
REQ-036 Reset mid-count: DIV=1, load 7, pulse rst after 3 ticks -> out=0, state=IDLE, busy=0, no borrow; further ticks do not move out.
REQ-037 DIV=1 stress: load 0 with one_shot=1 -> DONE and a borrow pulse one cycle after load.
